// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between the instruction fetcher and the load/store buffer.
// LSB requests win over fetches; misbranch flushes speculative reads but never stores.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        misbranch_flag,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_start,
  input  logic [31:0] if_pc,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        lsb_start,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_size,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata
);

  typedef enum logic [1:0] {StIdle, StIfRead, StLsRead, StLsWrite} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_if_q, pend_if_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        pend_ls_q, pend_ls_d;
  logic        ls_wr_q, ls_wr_d;
  logic [31:0] ls_addr_q, ls_addr_d;
  logic [2:0]  ls_size_q, ls_size_d;
  logic [31:0] ls_wdata_q, ls_wdata_d;
  logic [31:0] op_addr_q, op_addr_d;
  logic [2:0]  op_n_q, op_n_d;
  logic [31:0] op_wdata_q, op_wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  // Request view combining latched requests with same-cycle start pulses.
  logic        if_new, ls_new, if_req, ls_req, io_stall;
  logic        ls_req_wr;
  logic [31:0] ls_req_addr, ls_req_wdata, if_req_pc;
  logic [2:0]  ls_req_size, ls_req_n;
  logic [1:0]  rd_idx;

  always_comb begin
    if_new       = if_start & ~misbranch_flag;
    ls_new       = lsb_start & ~(misbranch_flag & ~lsb_wr);
    if_req       = if_new | (pend_if_q & ~misbranch_flag);
    ls_req       = ls_new | (pend_ls_q & ~(misbranch_flag & ~ls_wr_q));
    if_req_pc    = if_new ? if_pc : if_pc_q;
    ls_req_wr    = ls_new ? lsb_wr : ls_wr_q;
    ls_req_addr  = ls_new ? lsb_addr : ls_addr_q;
    ls_req_size  = ls_new ? lsb_size : ls_size_q;
    ls_req_wdata = ls_new ? lsb_wdata : ls_wdata_q;
    ls_req_n     = (ls_req_size > 3'd4) ? 3'd4 : ls_req_size;
    io_stall     = ls_req & ls_req_wr & (ls_req_addr[17:16] == 2'b11) & io_buffer_full;
    rd_idx       = 2'(cnt_q - 3'd1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 3'd1;
    pend_if_d   = if_req;
    if_pc_d     = if_req_pc;
    pend_ls_d   = ls_req;
    ls_wr_d     = ls_req_wr;
    ls_addr_d   = ls_req_addr;
    ls_size_d   = ls_req_size;
    ls_wdata_d  = ls_req_wdata;
    op_addr_d   = op_addr_q;
    op_n_d      = op_n_q;
    op_wdata_d  = op_wdata_q;
    buf_d       = buf_q;
    mem_a_d     = '0;
    mem_dout_d  = '0;
    mem_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    lsb_rdata_d = lsb_rdata_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ls_req && !io_stall) begin
          state_d    = ls_req_wr ? StLsWrite : StLsRead;
          pend_ls_d  = 1'b0;
          op_addr_d  = ls_req_addr;
          op_n_d     = ls_req_n;
          op_wdata_d = ls_req_wdata;
          buf_d      = '0;
        end else if (if_req && !io_stall) begin
          state_d   = StIfRead;
          pend_if_d = 1'b0;
          op_addr_d = if_req_pc;
          op_n_d    = 3'd4;
          buf_d     = '0;
        end
      end
      StIfRead, StLsRead: begin
        if (misbranch_flag) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          if (cnt_q < op_n_q) mem_a_d = op_addr_q + 32'(cnt_q);
          // Byte issued one edge earlier is on mem_din now.
          if (cnt_q != 3'd0 && cnt_q <= op_n_q) buf_d[{rd_idx, 3'b000} +: 8] = mem_din;
          if (cnt_q == 3'(op_n_q + 3'd1)) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (state_q == StIfRead) begin
              if_done_d = 1'b1;
              if_inst_d = buf_q;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_q;
            end
          end
        end
      end
      StLsWrite: begin
        if (cnt_q < op_n_q) begin
          mem_a_d    = op_addr_q + 32'(cnt_q);
          mem_dout_d = op_wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
        end else begin
          state_d    = StIdle;
          cnt_d      = '0;
          lsb_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_if_q   <= 1'b0;
      if_pc_q     <= '0;
      pend_ls_q   <= 1'b0;
      ls_wr_q     <= 1'b0;
      ls_addr_q   <= '0;
      ls_size_q   <= '0;
      ls_wdata_q  <= '0;
      op_addr_q   <= '0;
      op_n_q      <= '0;
      op_wdata_q  <= '0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_inst_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_if_q   <= pend_if_d;
      if_pc_q     <= if_pc_d;
      pend_ls_q   <= pend_ls_d;
      ls_wr_q     <= ls_wr_d;
      ls_addr_q   <= ls_addr_d;
      ls_size_q   <= ls_size_d;
      ls_wdata_q  <= ls_wdata_d;
      op_addr_q   <= op_addr_d;
      op_n_q      <= op_n_d;
      op_wdata_q  <= op_wdata_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_inst_q   <= if_inst_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  // Freeze hides strobes; they reappear for their one cycle once rdy returns.
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q & rdy;
  assign if_done   = if_done_q & rdy;
  assign lsb_done  = lsb_done_q & rdy;
  assign if_inst   = if_inst_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus a short random sequence,
// with a combinational RAM model and a negedge monitor popping expected results.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, misbranch_flag, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_start, if_done;
  logic [31:0] if_pc, if_inst;
  logic        lsb_start, lsb_wr, lsb_done;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic [2:0]  lsb_size;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .misbranch_flag (misbranch_flag),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .if_start       (if_start),
    .if_pc          (if_pc),
    .if_done        (if_done),
    .if_inst        (if_inst),
    .lsb_start      (lsb_start),
    .lsb_wr         (lsb_wr),
    .lsb_addr       (lsb_addr),
    .lsb_size       (lsb_size),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  assign mem_din = ram[mem_a[15:0]];

  typedef struct {logic [31:0] addr; logic [7:0] data;} wr_t;
  typedef struct {bit st; logic [31:0] data;} ls_t;
  logic [31:0] if_q[$];
  ls_t         ls_q[$];
  wr_t         wr_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] addr, input int n);
    logic [31:0] r, a;
    r = '0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      r[8*k +: 8] = ram[a[15:0]];
    end
    return r;
  endfunction

  // Monitor: sample outputs at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (if_done) begin
      if (if_q.size() == 0) check("if_done unexpected", {31'b0, if_done}, 32'd0);
      else check("if_inst", if_inst, if_q.pop_front());
    end
    if (lsb_done) begin
      if (ls_q.size() == 0) check("lsb_done unexpected", {31'b0, lsb_done}, 32'd0);
      else begin
        ls_t e;
        e = ls_q.pop_front();
        if (!e.st) check("lsb_rdata", lsb_rdata, e.data);
      end
    end
    if (mem_wr) begin
      if (wr_q.size() == 0) check("mem_wr unexpected", {31'b0, mem_wr}, 32'd0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        check("wr addr", mem_a, w.addr);
        check("wr data", {24'b0, mem_dout}, {24'b0, w.data});
      end
      ram[mem_a[15:0]] = mem_dout;
    end
  end

  task automatic issue_fetch(input logic [31:0] pc, input bit push);
    if (push) if_q.push_back(exp_read(pc, 4));
    if_pc = pc; if_start = 1'b1;
    step();
    if_start = 1'b0;
  endtask

  task automatic issue_load(input logic [31:0] addr, input logic [2:0] size, input bit push);
    ls_t e;
    e.st = 1'b0; e.data = exp_read(addr, int'(size));
    if (push) ls_q.push_back(e);
    lsb_addr = addr; lsb_size = size; lsb_wr = 1'b0; lsb_start = 1'b1;
    step();
    lsb_start = 1'b0;
  endtask

  task automatic push_store(input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata);
    ls_t e;
    wr_t w;
    for (int k = 0; k < int'(size); k++) begin
      w.addr = addr + 32'(k); w.data = wdata[8*k +: 8];
      wr_q.push_back(w);
    end
    e.st = 1'b1; e.data = '0;
    ls_q.push_back(e);
  endtask

  task automatic issue_store(input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata, input bit push);
    if (push) push_store(addr, size, wdata);
    lsb_addr = addr; lsb_size = size; lsb_wr = 1'b1; lsb_wdata = wdata; lsb_start = 1'b1;
    step();
    lsb_start = 1'b0;
  endtask

  task automatic wait_done(input bit is_if, input int lim, output int n);
    n = 0;
    while (!(is_if ? if_done : lsb_done)) begin
      if (n >= lim) begin
        check(is_if ? "if_done timeout" : "lsb_done timeout",
              {31'b0, is_if ? if_done : lsb_done}, 32'd1);
        return;
      end
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [2:0] sizes [3];
    sizes[0] = 3'd1; sizes[1] = 3'd2; sizes[2] = 3'd4;
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'h5a;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h0020] = 8'ha5;
    rst = 1'b1; rdy = 1'b1; misbranch_flag = 1'b0; io_buffer_full = 1'b0;
    if_start = 1'b0; if_pc = '0; lsb_start = 1'b0; lsb_wr = 1'b0;
    lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
    step(2);
    rst = 1'b0;

    // Reset state
    check("rst mem_a", mem_a, 32'd0);
    check("rst mem_dout", {24'b0, mem_dout}, 32'd0);
    check("rst mem_wr", {31'b0, mem_wr}, 32'd0);
    check("rst if_done", {31'b0, if_done}, 32'd0);
    check("rst lsb_done", {31'b0, lsb_done}, 32'd0);
    check("rst if_inst", if_inst, 32'd0);
    check("rst lsb_rdata", lsb_rdata, 32'd0);
    step();

    // Fetch: four byte reads, done after edge 6
    issue_fetch(32'h1000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("fetch mem_a", mem_a, 32'h1000 + 32'(k));
      check("fetch mem_wr", {31'b0, mem_wr}, 32'd0);
    end
    step();
    check("fetch no early done", {31'b0, if_done}, 32'd0);
    step();
    check("fetch done edge6", {31'b0, if_done}, 32'd1);
    step();
    check("fetch done one cycle", {31'b0, if_done}, 32'd0);

    // Collision: LSB load wins, fetch follows one cycle after lsb_done
    if_q.push_back(exp_read(32'h1000, 4));
    begin
      ls_t e;
      e.st = 1'b0; e.data = 32'h0000_00a5;
      ls_q.push_back(e);
    end
    if_pc = 32'h1000; if_start = 1'b1;
    lsb_addr = 32'h20; lsb_size = 3'd1; lsb_wr = 1'b0; lsb_start = 1'b1;
    step();
    if_start = 1'b0; lsb_start = 1'b0;
    step();
    check("collide load addr", mem_a, 32'h20);
    step(2);
    check("collide lsb_done", {31'b0, lsb_done}, 32'd1);
    check("collide no if_done", {31'b0, if_done}, 32'd0);
    step(2);
    check("collide fetch start", mem_a, 32'h1000);
    wait_done(1'b1, 12, n);
    check("collide fetch latency", 32'(n), 32'd5);
    step();

    // Store wrapping past 0xFFFFFFFF
    issue_store(32'hffff_ffff, 3'd2, 32'h0000_abcd, 1'b1);
    step();
    check("store b0 addr", mem_a, 32'hffff_ffff);
    check("store b0 data", {24'b0, mem_dout}, 32'h0000_00cd);
    check("store b0 wr", {31'b0, mem_wr}, 32'd1);
    step();
    check("store b1 addr", mem_a, 32'h0000_0000);
    check("store b1 data", {24'b0, mem_dout}, 32'h0000_00ab);
    step();
    check("store done edge3", {31'b0, lsb_done}, 32'd1);
    check("store wr low at done", {31'b0, mem_wr}, 32'd0);
    step();

    // Flush at edge 3 of a fetch; a store latched meanwhile still runs
    issue_fetch(32'h1000, 1'b0);
    push_store(32'h100, 3'd1, 32'h5a);
    lsb_addr = 32'h100; lsb_size = 3'd1; lsb_wr = 1'b1; lsb_wdata = 32'h5a; lsb_start = 1'b1;
    step();
    lsb_start = 1'b0;
    step();
    misbranch_flag = 1'b1; if_pc = 32'h1000; if_start = 1'b1;
    step();
    misbranch_flag = 1'b0; if_start = 1'b0;
    check("flush no if_done", {31'b0, if_done}, 32'd0);
    check("flush mem_a idle", mem_a, 32'd0);
    step();
    check("flush store edge0", {31'b0, mem_wr}, 32'd0);
    step();
    check("flush store wr", {31'b0, mem_wr}, 32'd1);
    check("flush store addr", mem_a, 32'h100);
    step();
    check("flush store done", {31'b0, lsb_done}, 32'd1);
    step(8);

    // I/O stall: store and a later fetch wait while the UART buffer is full
    ram[16'h1004] = 8'h44; ram[16'h1005] = 8'h33; ram[16'h1006] = 8'h22; ram[16'h1007] = 8'h11;
    io_buffer_full = 1'b1;
    issue_store(32'h0003_0000, 3'd1, 32'h77, 1'b1);
    issue_fetch(32'h1004, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("io stall mem_wr", {31'b0, mem_wr}, 32'd0);
      check("io stall fetch held", mem_a, 32'd0);
    end
    io_buffer_full = 1'b0;
    step();
    check("io edge0 no wr", {31'b0, mem_wr}, 32'd0);
    step();
    check("io write wr", {31'b0, mem_wr}, 32'd1);
    check("io write addr", mem_a, 32'h0003_0000);
    step();
    check("io store done", {31'b0, lsb_done}, 32'd1);
    wait_done(1'b1, 12, n);
    step();

    // rdy low for 3 cycles mid-read; start pulses are ignored meanwhile
    issue_load(32'h1000, 3'd4, 1'b1);
    step();
    check("rdy load b0", mem_a, 32'h1000);
    step();
    check("rdy load b1", mem_a, 32'h1001);
    rdy = 1'b0; if_pc = 32'h1000; if_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if_start = 1'b0;
      check("rdy hold mem_a", mem_a, 32'h1001);
      check("rdy mem_wr low", {31'b0, mem_wr}, 32'd0);
      check("rdy no done", {31'b0, lsb_done}, 32'd0);
    end
    rdy = 1'b1;
    wait_done(1'b0, 12, n);
    check("rdy delayed done", 32'(n), 32'd4);
    step(8);

    // Reset mid-read and mid-write: no done, no further writes, outputs cleared
    issue_load(32'h1000, 3'd4, 1'b0);
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst mem_a", mem_a, 32'd0);
    check("midrst if_inst", if_inst, 32'd0);
    check("midrst lsb_rdata", lsb_rdata, 32'd0);
    step(8);
    begin
      wr_t w;
      w.addr = 32'h300; w.data = 8'hef;
      wr_q.push_back(w);
    end
    issue_store(32'h300, 3'd4, 32'hdead_beef, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst write stopped", {31'b0, mem_wr}, 32'd0);
    step(8);

    // Short random sequence through the scoreboard
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a, d;
      logic [2:0]  sz;
      a  = 32'h400 + 32'($urandom_range(0, 255));
      d  = $urandom;
      sz = sizes[$urandom_range(0, 2)];
      case ($urandom_range(0, 2))
        0: begin issue_fetch(a, 1'b1); wait_done(1'b1, 12, n); end
        1: begin issue_load(a, sz, 1'b1); wait_done(1'b0, 12, n); end
        default: begin issue_store(a, sz, d, 1'b1); wait_done(1'b0, 12, n); end
      endcase
      step();
    end
    step(4);

    check("if queue drained", 32'(if_q.size()), 32'd0);
    check("ls queue drained", 32'(ls_q.size()), 32'd0);
    check("wr queue drained", 32'(wr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
